// File: rtl/sync_filter_nbit_pkg.sv
// Shared constants and helpers for the level synchroniser / glitch filter.
// Also reused by the UART RX front end.
package sync_filter_nbit_pkg;

   localparam int SYNC_DEPTH_DEF = 2;
   localparam int FILT_CNT_DEF   = 4;

   // Bits needed to hold values 0 .. value-1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/sync_filter_nbit_ch.sv
// One channel: sync chain, stability counter, filtered level, edge pulses.
// Ports: dst_clk_i, dst_rstn_i, src_data_i -> dst_data_o, rise_o, fall_o.
module sync_filter_ch
   import sync_filter_nbit_pkg::*;
#(
   parameter int   SYNC_DEPTH = SYNC_DEPTH_DEF,
   parameter int   FILT_CNT   = FILT_CNT_DEF,
   parameter logic RST_VAL    = 1'b0
) (
   input  logic dst_clk_i,
   input  logic dst_rstn_i,
   input  logic src_data_i,
   output logic dst_data_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = clog2(FILT_CNT + 1);

   if (SYNC_DEPTH < 2 || FILT_CNT < 1) begin : g_bad_param
      $error("sync_filter_ch: need SYNC_DEPTH >= 2 and FILT_CNT >= 1");
   end

   (* ASYNC_REG = "TRUE" *)
   logic [SYNC_DEPTH-1:0] sync_q;

   logic          s;
   logic          q;
   logic          load;
   logic [CW-1:0] cnt;

   always_ff @(posedge dst_clk_i or negedge dst_rstn_i) begin
      if (!dst_rstn_i) begin
         sync_q <= {SYNC_DEPTH{RST_VAL}};
      end else begin
         sync_q <= {sync_q[SYNC_DEPTH-2:0], src_data_i};
      end
   end

   assign s = sync_q[SYNC_DEPTH-1];

   // Accept on the FILT_CNT-th consecutive cycle that s disagrees with q.
   always_comb begin
      load = 1'b0;
      if (s != q && cnt == CW'(FILT_CNT - 1)) begin
         load = 1'b1;
      end
   end

   always_ff @(posedge dst_clk_i or negedge dst_rstn_i) begin
      if (!dst_rstn_i) begin
         q      <= RST_VAL;
         cnt    <= '0;
         rise_o <= 1'b0;
         fall_o <= 1'b0;
      end else begin
         rise_o <= load & s;
         fall_o <= load & ~s;
         if (s == q) begin
            cnt <= '0;
         end else if (load) begin
            q   <= s;
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign dst_data_o = q;

endmodule

// File: rtl/sync_filter_nbit.sv
// WIDTH independent synchronise-and-filter channels with edge pulses.
// Ports: dst_clk_i, dst_rstn_i, src_data_i[W] -> dst_data_o, rise_o, fall_o.
module sync_filter_nbit
   import sync_filter_nbit_pkg::*;
#(
   parameter int               WIDTH      = 1,
   parameter int               SYNC_DEPTH = SYNC_DEPTH_DEF,
   parameter int               FILT_CNT   = FILT_CNT_DEF,
   parameter logic [WIDTH-1:0] RST_VAL    = {WIDTH{1'b0}}
) (
   input  logic             dst_clk_i,
   input  logic             dst_rstn_i,
   input  logic [WIDTH-1:0] src_data_i,
   output logic [WIDTH-1:0] dst_data_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      sync_filter_ch #(
         .SYNC_DEPTH (SYNC_DEPTH),
         .FILT_CNT   (FILT_CNT),
         .RST_VAL    (RST_VAL[i])
      ) u_ch (
         .dst_clk_i  (dst_clk_i),
         .dst_rstn_i (dst_rstn_i),
         .src_data_i (src_data_i[i]),
         .dst_data_o (dst_data_o[i]),
         .rise_o     (rise_o[i]),
         .fall_o     (fall_o[i])
      );
   end

endmodule
